// File: rtl/scoreboard_counter_array.sv
// rtl/scoreboard_counter_array.sv - debounced up/down score counters per channel with leader/tie detection
module scoreboard_counter_array #(
  parameter int NUM_CH  = 2,
  parameter int CNT_W   = 7,
  parameter int MAX_VAL = 99,
  parameter int DEB_CYC = 4,
  parameter int WRAP    = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CH-1:0]         inc_btn,
  input  logic [NUM_CH-1:0]         dec_btn,
  input  logic                      clr,
  input  logic [$clog2(NUM_CH)-1:0] sel,
  output logic [NUM_CH*CNT_W-1:0]   score_out,
  output logic [CNT_W-1:0]          sel_score,
  output logic [NUM_CH-1:0]         step_evt,
  output logic [NUM_CH-1:0]         limit_evt,
  output logic [$clog2(NUM_CH)-1:0] leader,
  output logic                      tie
);
  localparam int SEL_W = $clog2(NUM_CH);
  localparam int NB    = 2 * NUM_CH;
  localparam int DEB_W = $clog2(DEB_CYC + 1);
  localparam logic [CNT_W-1:0] MAX_S    = CNT_W'(MAX_VAL);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYC - 1);

  // Buttons are handled as one vector: increments low, decrements high.
  logic [NB-1:0]     btn;
  logic [NB-1:0]     sync1_q, sync2_q;
  logic [NB-1:0]     lvl_q, lvl_d, lvl_dly_q;
  logic [DEB_W-1:0]  cnt_q [NB];
  logic [DEB_W-1:0]  cnt_d [NB];
  logic [NB-1:0]     press;
  logic [NUM_CH-1:0] inc_p, dec_p;
  logic [CNT_W-1:0]  score_q [NUM_CH];
  logic [CNT_W-1:0]  score_d [NUM_CH];
  logic [NUM_CH-1:0] step_q, step_d, limit_q, limit_d;
  logic [CNT_W-1:0]  max_v;
  logic              seen;

  assign btn   = {dec_btn, inc_btn};
  assign press = lvl_q & ~lvl_dly_q;
  assign inc_p = press[NUM_CH-1:0];
  assign dec_p = press[NB-1:NUM_CH];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      lvl_q     <= '0;
      lvl_dly_q <= '0;
      step_q    <= '0;
      limit_q   <= '0;
      for (int b = 0; b < NB; b++) cnt_q[b] <= '0;
      for (int i = 0; i < NUM_CH; i++) score_q[i] <= '0;
    end else begin
      sync1_q   <= btn;
      sync2_q   <= sync1_q;
      lvl_q     <= lvl_d;
      lvl_dly_q <= lvl_q;
      step_q    <= step_d;
      limit_q   <= limit_d;
      for (int b = 0; b < NB; b++) cnt_q[b] <= cnt_d[b];
      for (int i = 0; i < NUM_CH; i++) score_q[i] <= score_d[i];
    end
  end

  always_comb begin
    lvl_d = lvl_q;
    for (int b = 0; b < NB; b++) begin
      cnt_d[b] = '0;
      if (sync2_q[b] != lvl_q[b]) begin
        if (cnt_q[b] == DEB_LAST) lvl_d[b] = ~lvl_q[b];
        else cnt_d[b] = cnt_q[b] + DEB_W'(1);
      end
    end
  end

  // Opposing presses in the same cycle cancel; clr discards any press.
  always_comb begin
    step_d  = '0;
    limit_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      score_d[i] = score_q[i];
      if (clr) begin
        score_d[i] = '0;
      end else if (inc_p[i] && !dec_p[i]) begin
        if (score_q[i] == MAX_S) begin
          limit_d[i] = 1'b1;
          if (WRAP != 0) begin
            score_d[i] = '0;
            step_d[i]  = 1'b1;
          end
        end else begin
          score_d[i] = score_q[i] + CNT_W'(1);
          step_d[i]  = 1'b1;
        end
      end else if (dec_p[i] && !inc_p[i]) begin
        if (score_q[i] == '0) begin
          limit_d[i] = 1'b1;
          if (WRAP != 0) begin
            score_d[i] = MAX_S;
            step_d[i]  = 1'b1;
          end
        end else begin
          score_d[i] = score_q[i] - CNT_W'(1);
          step_d[i]  = 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
    assign score_out[g*CNT_W +: CNT_W] = score_q[g];
  end

  assign step_evt  = step_q;
  assign limit_evt = limit_q;

  always_comb begin
    sel_score = score_q[0];
    if (int'(sel) < NUM_CH) sel_score = score_q[sel];
  end

  // Strict compare keeps the lowest index among equal maxima.
  always_comb begin
    max_v  = score_q[0];
    leader = '0;
    tie    = 1'b0;
    seen   = 1'b0;
    for (int i = 1; i < NUM_CH; i++) begin
      if (score_q[i] > max_v) begin
        max_v  = score_q[i];
        leader = SEL_W'(i);
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (score_q[i] == max_v) begin
        if (seen) tie = 1'b1;
        seen = 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_scoreboard_counter_array.sv
// tb/tb_scoreboard_counter_array.sv - bench for scoreboard_counter_array, saturating and wrapping variants side by side
module tb_scoreboard_counter_array;
  localparam int D    = 4;
  localparam int MAXV = 99;

  logic        clk = 1'b0;
  logic        rst, clr;
  logic [1:0]  inc_btn, dec_btn;
  logic [0:0]  sel;
  logic [13:0] so0, so1;
  logic [6:0]  ss0, ss1;
  logic [1:0]  st0, st1, lm0, lm1;
  logic [0:0]  ld0, ld1;
  logic        tie0, tie1;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  scoreboard_counter_array #(.WRAP(0)) dut0 (
    .clk(clk), .rst(rst), .inc_btn(inc_btn), .dec_btn(dec_btn), .clr(clr), .sel(sel),
    .score_out(so0), .sel_score(ss0), .step_evt(st0), .limit_evt(lm0), .leader(ld0), .tie(tie0));

  scoreboard_counter_array #(.WRAP(1)) dut1 (
    .clk(clk), .rst(rst), .inc_btn(inc_btn), .dec_btn(dec_btn), .clr(clr), .sel(sel),
    .score_out(so1), .sel_score(ss1), .step_evt(st1), .limit_evt(lm1), .leader(ld1), .tie(tie1));

  // Model state: index w=0 saturating instance, w=1 wrapping instance.
  bit model_ok = 1'b0;
  int h [4][D+1];
  bit lvl_m [4];
  bit lvd_m [4];
  int m_sc [2][2];
  bit m_st [2][2];
  bit m_lm [2][2];
  int ev_step [2][2];
  int ev_lim [2][2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else n_pass++;
  endtask

  task automatic apply(input int w, input int ch, input bit ip, input bit dp, input bit c);
    int s;
    s = m_sc[w][ch];
    m_st[w][ch] = 1'b0;
    m_lm[w][ch] = 1'b0;
    if (c) begin
      m_sc[w][ch] = 0;
    end else if (ip && !dp) begin
      if (s == MAXV) begin
        m_lm[w][ch] = 1'b1;
        if (w == 1) begin m_sc[w][ch] = 0; m_st[w][ch] = 1'b1; end
      end else begin
        m_sc[w][ch] = s + 1; m_st[w][ch] = 1'b1;
      end
    end else if (dp && !ip) begin
      if (s == 0) begin
        m_lm[w][ch] = 1'b1;
        if (w == 1) begin m_sc[w][ch] = MAXV; m_st[w][ch] = 1'b1; end
      end else begin
        m_sc[w][ch] = s - 1; m_st[w][ch] = 1'b1;
      end
    end
  endtask

  function automatic void best(input int w, output int ld, output bit tt);
    int mx, n;
    mx = -1; ld = 0; n = 0;
    for (int ch = 0; ch < 2; ch++) if (m_sc[w][ch] > mx) begin mx = m_sc[w][ch]; ld = ch; end
    for (int ch = 0; ch < 2; ch++) if (m_sc[w][ch] == mx) n++;
    tt = (n > 1);
  endfunction

  // A level is accepted once the last D synchronized samples all disagree with it.
  always @(posedge clk) begin : mdl
    bit ip, dp, flip;
    if (rst) begin
      model_ok = 1'b1;
      for (int b = 0; b < 4; b++) begin
        lvl_m[b] = 1'b0; lvd_m[b] = 1'b0;
        for (int j = 0; j <= D; j++) h[b][j] = 0;
      end
      for (int w = 0; w < 2; w++)
        for (int ch = 0; ch < 2; ch++) begin
          m_sc[w][ch] = 0; m_st[w][ch] = 1'b0; m_lm[w][ch] = 1'b0;
        end
    end else begin
      for (int ch = 0; ch < 2; ch++) begin
        ip = lvl_m[ch] && !lvd_m[ch];
        dp = lvl_m[ch+2] && !lvd_m[ch+2];
        for (int w = 0; w < 2; w++) apply(w, ch, ip, dp, clr);
      end
      for (int b = 0; b < 4; b++) begin
        lvd_m[b] = lvl_m[b];
        flip = 1'b1;
        for (int j = 1; j <= D; j++) if (h[b][j] == int'(lvl_m[b])) flip = 1'b0;
        if (flip) lvl_m[b] = !lvl_m[b];
        for (int j = D; j >= 1; j--) h[b][j] = h[b][j-1];
        h[b][0] = (b < 2) ? int'(inc_btn[b]) : int'(dec_btn[b-2]);
      end
    end
  end

  task automatic cmp(input int w, input logic [13:0] so, input logic [6:0] ss, input logic [1:0] st,
                     input logic [1:0] lm, input logic [0:0] ld, input logic ti);
    int eld;
    bit ett;
    best(w, eld, ett);
    chk($sformatf("w%0d_score_out", w), 32'(so), 32'(m_sc[w][1] * 128 + m_sc[w][0]));
    chk($sformatf("w%0d_sel_score", w), 32'(ss), 32'(m_sc[w][sel]));
    chk($sformatf("w%0d_step_evt", w), 32'(st), 32'(int'(m_st[w][1]) * 2 + int'(m_st[w][0])));
    chk($sformatf("w%0d_limit_evt", w), 32'(lm), 32'(int'(m_lm[w][1]) * 2 + int'(m_lm[w][0])));
    chk($sformatf("w%0d_leader", w), 32'(ld), 32'(eld));
    chk($sformatf("w%0d_tie", w), 32'(ti), 32'(ett));
    for (int ch = 0; ch < 2; ch++) begin
      if (st[ch] === 1'b1) ev_step[w][ch]++;
      if (lm[ch] === 1'b1) ev_lim[w][ch]++;
    end
  endtask

  always @(posedge clk) begin
    #2;
    if (model_ok) begin
      cmp(0, so0, ss0, st0, lm0, ld0, tie0);
      cmp(1, so1, ss1, st1, lm1, ld1, tie1);
    end
  end

  task automatic clear_ev();
    for (int w = 0; w < 2; w++)
      for (int ch = 0; ch < 2; ch++) begin ev_step[w][ch] = 0; ev_lim[w][ch] = 0; end
  endtask

  task automatic press(input logic [1:0] inc_m, input logic [1:0] dec_m, input int n);
    for (int k = 0; k < n; k++) begin
      sel = ~sel;
      inc_btn = inc_m; dec_btn = dec_m;
      repeat (D + 3) @(negedge clk);
      inc_btn = 2'b00; dec_btn = 2'b00;
      repeat (D + 3) @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; inc_btn = 2'b00; dec_btn = 2'b00; sel = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_score0", 32'(so0), 0);
    chk("rst_score1", 32'(so1), 0);
    chk("rst_tie", 32'(tie0), 1);
    chk("rst_leader", 32'(ld0), 0);
    chk("rst_step", 32'(st1), 0);
    rst = 1'b0;

    inc_btn = 2'b01;
    repeat (6) @(negedge clk);
    chk("lat_e5_score", 32'(so0[6:0]), 0);
    @(negedge clk);
    chk("lat_e6_score", 32'(so0[6:0]), 1);
    chk("lat_e6_step", 32'(st0), 1);
    chk("lat_e6_leader", 32'(ld0), 0);
    chk("lat_e6_tie", 32'(tie0), 0);
    chk("model_lat", 32'(m_sc[0][0]), 1);
    inc_btn = 2'b00;
    repeat (12) @(negedge clk);

    clear_ev();
    inc_btn = 2'b10; repeat (3) @(negedge clk); inc_btn = 2'b00;
    repeat (12) @(negedge clk);
    chk("glitch3_score", 32'(so0[13:7]), 0);
    chk("glitch3_step", 32'(ev_step[0][1]), 0);
    inc_btn = 2'b10; repeat (4) @(negedge clk); inc_btn = 2'b00;
    repeat (12) @(negedge clk);
    chk("glitch4_score", 32'(so0[13:7]), 1);
    chk("glitch4_step", 32'(ev_step[0][1]), 1);

    press(2'b01, 2'b00, 98);
    chk("top_w0", 32'(so0[6:0]), 99);
    chk("top_w1", 32'(so1[6:0]), 99);
    chk("model_top", 32'(m_sc[1][0]), 99);
    clear_ev();
    press(2'b01, 2'b00, 1);
    chk("sat_score", 32'(so0[6:0]), 99);
    chk("sat_limit", 32'(ev_lim[0][0]), 1);
    chk("sat_step", 32'(ev_step[0][0]), 0);
    chk("wrap_score", 32'(so1[6:0]), 0);
    chk("wrap_limit", 32'(ev_lim[1][0]), 1);
    chk("wrap_step", 32'(ev_step[1][0]), 1);

    press(2'b00, 2'b10, 1);
    chk("dec_to0", 32'(so1[13:7]), 0);
    clear_ev();
    press(2'b00, 2'b10, 1);
    chk("wrapdn_score", 32'(so1[13:7]), 99);
    chk("wrapdn_limit", 32'(ev_lim[1][1]), 1);
    chk("wrapdn_step", 32'(ev_step[1][1]), 1);
    chk("satdn_score", 32'(so0[13:7]), 0);
    chk("satdn_limit", 32'(ev_lim[0][1]), 1);
    chk("satdn_step", 32'(ev_step[0][1]), 0);
    clear_ev();
    press(2'b10, 2'b10, 1);
    chk("both_score", 32'(so1[13:7]), 99);
    chk("both_step", 32'(ev_step[1][1]), 0);
    chk("both_limit", 32'(ev_lim[1][1]), 0);
    chk("both_leader", 32'(ld1), 1);

    clr = 1'b1; @(negedge clk); clr = 1'b0; @(negedge clk);
    press(2'b11, 2'b00, 5);
    chk("tie55_score", 32'(so1), 5 * 128 + 5);
    chk("tie55_tie", 32'(tie0), 1);
    chk("tie55_leader", 32'(ld0), 0);
    clear_ev();
    inc_btn = 2'b10;
    repeat (6) @(negedge clk);
    clr = 1'b1; @(negedge clk); clr = 1'b0;
    chk("clr_score0", 32'(so0), 0);
    chk("clr_score1", 32'(so1), 0);
    inc_btn = 2'b00;
    repeat (12) @(negedge clk);
    chk("clr_step", 32'(ev_step[0][1] + ev_step[1][1]), 0);
    chk("clr_limit", 32'(ev_lim[0][1] + ev_lim[1][1]), 0);

    press(2'b11, 2'b00, 3);
    press(2'b01, 2'b00, 4);
    chk("s73_score", 32'(so0), 3 * 128 + 7);
    inc_btn = 2'b01;
    repeat (3) @(negedge clk);
    rst = 1'b1; @(negedge clk);
    chk("mrst_score0", 32'(so0), 0);
    chk("mrst_score1", 32'(so1), 0);
    chk("mrst_step", 32'(st0), 0);
    chk("mrst_limit", 32'(lm1), 0);
    chk("mrst_leader", 32'(ld0), 0);
    chk("mrst_tie", 32'(tie1), 1);
    sel = 1'b0; #1;
    chk("mrst_sel0", 32'(ss0), 0);
    sel = 1'b1; #1;
    chk("mrst_sel1", 32'(ss1), 0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("held_e5_score", 32'(so0[6:0]), 0);
    @(negedge clk);
    chk("held_e6_score", 32'(so0[6:0]), 1);
    inc_btn = 2'b00;
    repeat (12) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
